// File: rtl/reg_bank_pkg.sv
// Shared constants and word type for the reg_bank register file.
package reg_bank_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_bank_word.sv
// One register of the bank: synchronous active-high clear, load-enabled update.
import reg_bank_pkg::*;

module reg_bank_word #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register file: one write port, two combinational read ports.
// Define REG_BANK_BYPASS_EN to forward d_in onto a read port addressing the word being written.
import reg_bank_pkg::*;

module reg_bank #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [DEPTH-1:0]  written
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    logic             wr_valid;
    logic [DEPTH-1:0] word_en;
    logic [WIDTH-1:0] regs [DEPTH];

    // Addresses past the last register (non-power-of-2 DEPTH) never write.
    assign wr_valid = load && ({1'b0, wr_addr} < DEPTH_W);

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

        assign word_en[g] = wr_valid && (wr_addr == IDX);

        reg_bank_word #(.WIDTH(WIDTH)) u_word (
            .clk  (clk),
            .rst  (rst),
            .load (word_en[g]),
            .d    (d_in),
            .q    (regs[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            written <= '0;
        else
            written <= written | word_en;
    end

    // Unmatched (out-of-range) read addresses fall through to zero.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i))
                out_a = regs[i];
            if (rd_addr_b == ADDR_W'(i))
                out_b = regs[i];
        end
`ifdef REG_BANK_BYPASS_EN
        if (!rst && wr_valid && (rd_addr_a == wr_addr))
            out_a = d_in;
        if (!rst && wr_valid && (rd_addr_b == wr_addr))
            out_b = d_in;
`endif
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each register.
REQ-002 Parameter DEPTH, default 8, number of registers; legal range 2..256.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width; not overridden by instantiators.
REQ-004 Port clk  input  1  sole clock, rising-edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port load  input  1  write enable for the write port.
REQ-007 Port wr_addr  input  ADDR_W  write address.
REQ-008 Port d_in  input  WIDTH  write data.
REQ-009 Port rd_addr_a  input  ADDR_W  read address, port A.
REQ-010 Port rd_addr_b  input  ADDR_W  read address, port B.
REQ-011 Port out_a  output  WIDTH  read data, port A.
REQ-012 Port out_b  output  WIDTH  read data, port B.
REQ-013 Port written  output  DEPTH  per-register flag, bit i set once register i has been written since reset.

Function
REQ-014 Write: on rising clk with rst=0, load=1, wr_addr<DEPTH, register[wr_addr] SHALL take d_in and written[wr_addr] SHALL set; other registers and flags unchanged.
REQ-015 load=0: no register or flag SHALL change (hold, like the 16-bit register).
REQ-016 Write with wr_addr>=DEPTH (non-power-of-2 DEPTH) SHALL be ignored entirely.
REQ-017 Reads SHALL be combinational: out_a = register[rd_addr_a], out_b = register[rd_addr_b]; read latency zero after the address settles.
REQ-018 Read with address >= DEPTH SHALL return all zeros.
REQ-019 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-020 Read of the address being written in the same cycle (bypass disabled) SHALL return the old contents until the clock edge, the new contents after it.
REQ-021 Data SHALL be stored without truncation or extension; d_in is exactly WIDTH bits.

Reset
REQ-022 On rising clk with rst=1, every register SHALL clear to 0 and written SHALL clear to 0, regardless of load.
REQ-023 rst=1 and load=1 in the same cycle: reset SHALL win; the write is discarded.
REQ-024 After reset, out_a and out_b SHALL read 0 for every address.
REQ-025 Before the first reset, register contents are undefined; the bench SHALL reset first.

Configuration
REQ-026 Macro REG_BANK_BYPASS_EN defined: when load=1, rst=0 and rd_addr_x equals a valid wr_addr, out_x SHALL present d_in combinationally (write-through) in that same cycle.
REQ-027 REG_BANK_BYPASS_EN undefined: no bypass; REQ-020 applies.
REQ-028 Bypass SHALL NOT apply while rst=1; reads then follow stored contents.

Structure
REQ-029 Shared package reg_bank_pkg SHALL hold the default WIDTH and DEPTH constants and the register-word typedef.
REQ-030 Sub-module reg_bank_word SHALL implement one WIDTH-bit register with load and synchronous reset; reg_bank instantiates DEPTH of them plus address decode and read muxes.

Verification
REQ-031 rst=1 for one clk, then read all addresses -> out_a=out_b=0, written=0.
REQ-032 load=1, wr_addr=3, d_in=1234, one clk; load=0 -> out_a(rd_addr_a=3)=1234, written=8'b0000_1000, others read 0.
REQ-033 load=0, d_in=16'hFFFF, two clks -> register 3 still 1234, written unchanged.
REQ-034 rd_addr_a=3, rd_addr_b=3, load=1, wr_addr=3, d_in=5678 before edge -> out_a=out_b=1234 (bypass off) or 5678 (REG_BANK_BYPASS_EN), both 5678 after edge.
REQ-035 rst=1 and load=1, wr_addr=5, d_in=99 same clk -> register 5 reads 0, written=0.
REQ-036 DEPTH=6: load=1, wr_addr=7, d_in=42 -> no flag set, all registers unchanged; rd_addr_a=7 -> out_a=0.
